mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MISALIGN_CODE, default 3'h4, SHALL be the exception code reported for an unaligned load/store.
REQ-002 cpu_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 cpu_rstn  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  pipeline hold from control unit (mem_stall).
REQ-005 flush  in  1  pipeline flush from control unit (mem_flush).
REQ-006 ex_en, ex_br_flag, ex_gpr_wen  in  1 each  EX/MEM valid, delay-slot flag, GPR write enable.
REQ-007 ex_pc  in  30  instruction word address.
REQ-008 ex_mem_op  in  2  0 none, 1 load word, 2 store word, 3 reserved (treated as none).
REQ-009 ex_ctrl_op  in  2; ex_dst_addr  in  5; ex_exp_code  in  3.
REQ-010 ex_out  in  32  ALU result / byte address; ex_wr_data  in  32  store data.
REQ-011 bus_req  out  1; bus_grant  in  1; bus_as  out  1 address strobe; bus_rw  out  1 (1 read, 0 write).
REQ-012 bus_addr  out  30; bus_wr_data  out  32; bus_rd_data  in  32; bus_rdy  in  1.
REQ-013 mem_en, mem_br_flag, mem_gpr_wen  out  1; mem_pc  out  30; mem_ctrl_op  out  2; mem_dst_addr  out  5; mem_exp_code  out  3; mem_out  out  32  MEM/WB register to control unit and write-back.
REQ-014 mem_busy  out  1  combinational; stalls the pipeline while an access is outstanding.

Function
REQ-015 access = ex_en & ~flush & (ex_mem_op==1|2) & ex_exp_code==0 & ex_out[1:0]==0.
REQ-016 misalign = ex_en & (ex_mem_op==1|2) & ex_exp_code==0 & ex_out[1:0]!=0; no bus cycle SHALL start.
REQ-017 FSM states IDLE, REQ, ACCESS, DONE; reset state IDLE.
REQ-018 IDLE: access -> REQ, bus_req=1 same cycle; else stay.
REQ-019 REQ: bus_req=1; flush -> IDLE, bus_req dropped, no strobe; bus_grant -> ACCESS.
REQ-020 ACCESS: bus_req=1, bus_as=1, bus_addr=ex_out[31:2], bus_rw=(ex_mem_op==1), bus_wr_data=ex_wr_data, all held stable until bus_rdy.
REQ-021 ACCESS & bus_rdy: rd_buf<=bus_rdy-cycle bus_rd_data; -> DONE; strobed cycle SHALL never be aborted, flush included.
REQ-022 DONE: bus outputs 0; -> IDLE on first cycle with stall==0.
REQ-023 mem_busy = (IDLE & access) | REQ | (ACCESS & ~bus_rdy); 0 in DONE and on the bus_rdy cycle.
REQ-024 Bus outputs SHALL be 0 in IDLE and DONE.
REQ-025 Register update when stall==0: flush -> all mem_* cleared to 0; else mem_* <= ex_* (pc, en, br_flag, ctrl_op, dst_addr).
REQ-026 mem_exp_code <= misalign ? MISALIGN_CODE : ex_exp_code.
REQ-027 mem_gpr_wen <= ex_gpr_wen & ~misalign & (ex_exp_code==0).
REQ-028 mem_out <= (ex_mem_op==1 & access-complete) ? load data (bus_rd_data on bus_rdy cycle, else rd_buf in DONE) : ex_out.
REQ-029 stall==1: all mem_* SHALL hold.
REQ-030 Flush during ACCESS: cycle completes, data discarded, registers cleared on first non-stalled edge.
REQ-031 Store: mem_out SHALL be ex_out; no GPR update implied beyond ex_gpr_wen.

Reset
REQ-032 cpu_rstn low SHALL asynchronously force state IDLE, rd_buf 0, every mem_* output 0, bus outputs 0, mem_busy 0 except per REQ-023 from ex_* inputs.
REQ-033 Reset mid-access SHALL abandon the bus cycle immediately (bus_as, bus_req low).

Verification
REQ-034 Load ex_out=0x100, grant after 2 cycles, rdy after 3 -> bus_addr=0x40, bus_rw=1, mem_busy high until rdy cycle, mem_out=bus_rd_data, mem_gpr_wen=1.
REQ-035 Store ex_out=0x8, ex_wr_data=0xDEADBEEF, immediate grant/rdy -> bus_rw=0, bus_wr_data=0xDEADBEEF, mem_out=0x8, busy 2 cycles.
REQ-036 Load ex_out=0x102 -> no bus_req, mem_exp_code=4, mem_gpr_wen=0, mem_busy=0.
REQ-037 Load completes while external stall held 3 more cycles -> state DONE, mem_out equals captured data, no second bus_req.
REQ-038 Flush in REQ -> bus_req drops, no bus_as; flush in ACCESS -> strobe held to rdy, then mem_en=0, mem_out=0.
REQ-039 cpu_rstn low during ACCESS -> bus_as=0, mem_* =0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus port bundle between the memory stage and the shared system bus.
// The memory stage is the master; the bus arbiter/target side is the slave.
interface mem_stage_if;
    logic        bus_req;
    logic        bus_grant;
    logic        bus_as;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy;

    modport master (
        output bus_req,
        output bus_as,
        output bus_rw,
        output bus_addr,
        output bus_wr_data,
        input  bus_grant,
        input  bus_rd_data,
        input  bus_rdy
    );

    modport slave (
        input  bus_req,
        input  bus_as,
        input  bus_rw,
        input  bus_addr,
        input  bus_wr_data,
        output bus_grant,
        output bus_rd_data,
        output bus_rdy
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: word load/store over a request/grant bus,
// misalignment trap and the MEM/WB pipeline register.
module mem_stage #(
    parameter logic [2:0] MISALIGN_CODE = 3'h4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic        ex_gpr_wen,
    input  logic [29:0] ex_pc,
    input  logic [1:0]  ex_mem_op,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    input  logic [31:0] ex_wr_data,
    mem_stage_if.master bus,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic        mem_gpr_wen,
    output logic [29:0] mem_pc,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out,
    output logic        mem_busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACCESS,
        DONE
    } state_e;

    state_e      state_q;
    logic [31:0] rd_buf_q;
    logic        flush_pend_q;

    logic        is_mem;
    logic        is_load;
    logic        eligible;
    logic        kill;
    logic        access;
    logic        misalign;
    logic        rdy_hit;
    logic        load_done;
    logic [31:0] mem_out_d;

    assign is_mem   = (ex_mem_op == 2'd1) | (ex_mem_op == 2'd2);
    assign is_load  = (ex_mem_op == 2'd1);
    assign eligible = ex_en & is_mem & (ex_exp_code == 3'd0);
    // A flush seen while stalled still kills the held EX instruction.
    assign kill     = flush | flush_pend_q;
    assign access   = eligible & ~kill & (ex_out[1:0] == 2'b00);
    assign misalign = eligible & (ex_out[1:0] != 2'b00);

    assign rdy_hit   = (state_q == ACCESS) & bus.bus_rdy;
    assign load_done = is_load & (rdy_hit | (state_q == DONE));
    assign mem_out_d = load_done ? (rdy_hit ? bus.bus_rd_data : rd_buf_q)
                                 : ex_out;

    always_comb begin
        mem_busy = 1'b0;
        unique case (state_q)
            IDLE:    mem_busy = access;
            REQ:     mem_busy = 1'b1;
            ACCESS:  mem_busy = ~bus.bus_rdy;
            DONE:    mem_busy = 1'b0;
            default: mem_busy = 1'b0;
        endcase
    end

    always_comb begin
        bus.bus_req     = 1'b0;
        bus.bus_as      = 1'b0;
        bus.bus_rw      = 1'b0;
        bus.bus_addr    = 30'd0;
        bus.bus_wr_data = 32'd0;
        unique case (state_q)
            IDLE:    bus.bus_req = access & cpu_rstn;
            REQ:     bus.bus_req = ~flush;
            ACCESS: begin
                bus.bus_req     = 1'b1;
                bus.bus_as      = 1'b1;
                bus.bus_rw      = is_load;
                bus.bus_addr    = ex_out[31:2];
                bus.bus_wr_data = ex_wr_data;
            end
            DONE:    ;
            default: ;
        endcase
    end

    // DONE only parks a completed access while the pipeline is held.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q  <= IDLE;
            rd_buf_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (access)
                        state_q <= REQ;
                end
                REQ: begin
                    if (flush)
                        state_q <= IDLE;
                    else if (bus.bus_grant)
                        state_q <= ACCESS;
                end
                ACCESS: begin
                    if (bus.bus_rdy) begin
                        rd_buf_q <= bus.bus_rd_data;
                        state_q  <= stall ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (!stall)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            flush_pend_q <= 1'b0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_gpr_wen  <= 1'b0;
            mem_pc       <= 30'd0;
            mem_ctrl_op  <= 2'd0;
            mem_dst_addr <= 5'd0;
            mem_exp_code <= 3'd0;
            mem_out      <= 32'd0;
        end else if (stall) begin
            if (flush)
                flush_pend_q <= 1'b1;
        end else begin
            flush_pend_q <= 1'b0;
            if (kill) begin
                mem_en       <= 1'b0;
                mem_br_flag  <= 1'b0;
                mem_gpr_wen  <= 1'b0;
                mem_pc       <= 30'd0;
                mem_ctrl_op  <= 2'd0;
                mem_dst_addr <= 5'd0;
                mem_exp_code <= 3'd0;
                mem_out      <= 32'd0;
            end else begin
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_gpr_wen  <= ex_gpr_wen & ~misalign
                                & (ex_exp_code == 3'd0);
                mem_pc       <= ex_pc;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_exp_code <= misalign ? MISALIGN_CODE : ex_exp_code;
                mem_out      <= mem_out_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load, store, misalign, stall hold,
// flush in REQ/ACCESS and asynchronous reset during a bus cycle.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ext_stall;
    logic        stall;
    logic        flush;
    logic        ex_en, ex_br_flag, ex_gpr_wen;
    logic [29:0] ex_pc;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out, ex_wr_data;
    logic        mem_en, mem_br_flag, mem_gpr_wen;
    logic [29:0] mem_pc;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt;

    mem_stage_if bif ();

    // Control unit model: hold the pipeline while the stage is busy.
    assign stall = busy | ext_stall;

    mem_stage dut (
        .cpu_clk      (clk),
        .cpu_rstn     (rstn),
        .stall        (stall),
        .flush        (flush),
        .ex_en        (ex_en),
        .ex_br_flag   (ex_br_flag),
        .ex_gpr_wen   (ex_gpr_wen),
        .ex_pc        (ex_pc),
        .ex_mem_op    (ex_mem_op),
        .ex_ctrl_op   (ex_ctrl_op),
        .ex_dst_addr  (ex_dst_addr),
        .ex_exp_code  (ex_exp_code),
        .ex_out       (ex_out),
        .ex_wr_data   (ex_wr_data),
        .bus          (bif),
        .mem_en       (mem_en),
        .mem_br_flag  (mem_br_flag),
        .mem_gpr_wen  (mem_gpr_wen),
        .mem_pc       (mem_pc),
        .mem_ctrl_op  (mem_ctrl_op),
        .mem_dst_addr (mem_dst_addr),
        .mem_exp_code (mem_exp_code),
        .mem_out      (mem_out),
        .mem_busy     (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nop();
        ex_en       = 1'b0;
        ex_mem_op   = 2'd0;
        ex_out      = 32'd0;
        ex_gpr_wen  = 1'b0;
        ex_wr_data  = 32'd0;
        ex_ctrl_op  = 2'd0;
        ex_pc       = 30'd0;
        ex_dst_addr = 5'd0;
    endtask

    task automatic set_ex(input logic [1:0] op, input logic [31:0] out,
                          input logic gw);
        ex_en      = 1'b1;
        ex_mem_op  = op;
        ex_out     = out;
        ex_gpr_wen = gw;
    endtask

    initial begin
        rstn = 1'b0;
        ext_stall = 1'b0;
        flush = 1'b0;
        ex_br_flag = 1'b0;
        ex_exp_code = 3'd0;
        nop();
        bif.bus_grant   = 1'b0;
        bif.bus_rdy     = 1'b0;
        bif.bus_rd_data = 32'd0;

        @(negedge clk);
        chk("rst_en", mem_en, 1'b0);
        chk("rst_out", mem_out, 32'd0);
        chk("rst_gw", mem_gpr_wen, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", bif.bus_req, 1'b0);
        chk("rst_as", bif.bus_as, 1'b0);
        rstn = 1'b1;

        // load 0x100, grant after 2 REQ cycles, rdy on 3rd ACCESS cycle
        @(negedge clk);
        set_ex(2'd1, 32'h100, 1'b1);
        ex_dst_addr = 5'd5;
        ex_pc = 30'h40;
        ex_ctrl_op = 2'd1;
        #1;
        chk("ld_req0", bif.bus_req, 1'b1);
        chk("ld_busy0", busy, 1'b1);
        chk("ld_as0", bif.bus_as, 1'b0);
        @(negedge clk);
        chk("ld_req1", bif.bus_req, 1'b1);
        chk("ld_as1", bif.bus_as, 1'b0);
        @(negedge clk);
        chk("ld_as2", bif.bus_as, 1'b0);
        bif.bus_grant = 1'b1;
        @(negedge clk);
        bif.bus_grant = 1'b0;
        chk("ld_as", bif.bus_as, 1'b1);
        chk("ld_addr", bif.bus_addr, 30'h40);
        chk("ld_rw", bif.bus_rw, 1'b1);
        chk("ld_busy", busy, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ld_hold_as", bif.bus_as, 1'b1);
            chk("ld_hold_addr", bif.bus_addr, 30'h40);
            chk("ld_hold_busy", busy, 1'b1);
        end
        bif.bus_rdy = 1'b1;
        bif.bus_rd_data = 32'hCAFEF00D;
        #1;
        chk("ld_rdy_busy", busy, 1'b0);
        @(negedge clk);
        bif.bus_rdy = 1'b0;
        bif.bus_rd_data = 32'hFFFFFFFF;
        chk("ld_out", mem_out, 32'hCAFEF00D);
        chk("ld_gw", mem_gpr_wen, 1'b1);
        chk("ld_en", mem_en, 1'b1);
        chk("ld_dst", mem_dst_addr, 5'd5);
        chk("ld_pc", mem_pc, 30'h40);
        chk("ld_ctrl", mem_ctrl_op, 2'd1);
        chk("ld_exp", mem_exp_code, 3'd0);
        nop();
        #1;
        chk("ld_after_req", bif.bus_req, 1'b0);

        // store 0x8 with immediate grant and rdy
        set_ex(2'd2, 32'h8, 1'b0);
        ex_wr_data = 32'hDEADBEEF;
        bif.bus_grant = 1'b1;
        bif.bus_rdy = 1'b1;
        busy_cnt = 0;
        #1;
        chk("st_req0", bif.bus_req, 1'b1);
        chk("st_as0", bif.bus_as, 1'b0);
        busy_cnt += int'(busy);
        @(negedge clk);
        chk("st_req1", bif.bus_req, 1'b1);
        chk("st_as1", bif.bus_as, 1'b0);
        busy_cnt += int'(busy);
        @(negedge clk);
        chk("st_as", bif.bus_as, 1'b1);
        chk("st_rw", bif.bus_rw, 1'b0);
        chk("st_wd", bif.bus_wr_data, 32'hDEADBEEF);
        chk("st_addr", bif.bus_addr, 30'h2);
        busy_cnt += int'(busy);
        @(negedge clk);
        chk("st_busy_cnt", busy_cnt, 32'd2);
        chk("st_out", mem_out, 32'h8);
        chk("st_gw", mem_gpr_wen, 1'b0);
        bif.bus_grant = 1'b0;
        bif.bus_rdy = 1'b0;

        // misaligned load
        set_ex(2'd1, 32'h102, 1'b1);
        ex_wr_data = 32'd0;
        #1;
        chk("mis_req", bif.bus_req, 1'b0);
        chk("mis_busy", busy, 1'b0);
        @(negedge clk);
        chk("mis_exp", mem_exp_code, 3'h4);
        chk("mis_gw", mem_gpr_wen, 1'b0);
        chk("mis_out", mem_out, 32'h102);

        // load completing under an external stall
        ext_stall = 1'b1;
        set_ex(2'd1, 32'h20, 1'b1);
        bif.bus_grant = 1'b1;
        bif.bus_rdy = 1'b1;
        bif.bus_rd_data = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        chk("stl_as", bif.bus_as, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bif.bus_rd_data = 32'd0;
            #1;
            chk("stl_req", bif.bus_req, 1'b0);
            chk("stl_as_done", bif.bus_as, 1'b0);
            chk("stl_busy", busy, 1'b0);
            chk("stl_hold", mem_out, 32'h102);
        end
        ext_stall = 1'b0;
        #1;
        chk("stl_rel_req", bif.bus_req, 1'b0);
        @(negedge clk);
        chk("stl_out", mem_out, 32'h12345678);
        chk("stl_gw", mem_gpr_wen, 1'b1);
        nop();
        bif.bus_grant = 1'b0;
        bif.bus_rdy = 1'b0;

        // flush while in REQ
        set_ex(2'd1, 32'h40, 1'b1);
        @(negedge clk);
        chk("fr_req", bif.bus_req, 1'b1);
        flush = 1'b1;
        #1;
        chk("fr_req_drop", bif.bus_req, 1'b0);
        chk("fr_as", bif.bus_as, 1'b0);
        @(negedge clk);
        chk("fr_idle_req", bif.bus_req, 1'b0);
        chk("fr_idle_as", bif.bus_as, 1'b0);
        chk("fr_idle_busy", busy, 1'b0);
        @(negedge clk);
        chk("fr_en", mem_en, 1'b0);
        chk("fr_out", mem_out, 32'd0);
        chk("fr_gw", mem_gpr_wen, 1'b0);
        flush = 1'b0;
        nop();

        // flush while in ACCESS
        set_ex(2'd0, 32'h55, 1'b1);
        ex_ctrl_op = 2'd2;
        ex_pc = 30'h7;
        @(negedge clk);
        chk("alu_out", mem_out, 32'h55);
        chk("alu_en", mem_en, 1'b1);
        chk("alu_ctrl", mem_ctrl_op, 2'd2);
        chk("alu_pc", mem_pc, 30'h7);
        set_ex(2'd1, 32'h80, 1'b1);
        bif.bus_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        bif.bus_grant = 1'b0;
        #1;
        chk("fa_as", bif.bus_as, 1'b1);
        chk("fa_req", bif.bus_req, 1'b1);
        chk("fa_busy", busy, 1'b1);
        @(negedge clk);
        chk("fa_as_hold", bif.bus_as, 1'b1);
        chk("fa_addr", bif.bus_addr, 30'h20);
        chk("fa_out_hold", mem_out, 32'h55);
        bif.bus_rdy = 1'b1;
        bif.bus_rd_data = 32'hBAD0BAD0;
        #1;
        chk("fa_rdy_busy", busy, 1'b0);
        @(negedge clk);
        chk("fa_en", mem_en, 1'b0);
        chk("fa_out", mem_out, 32'd0);
        chk("fa_as_end", bif.bus_as, 1'b0);
        flush = 1'b0;
        bif.bus_rdy = 1'b0;
        nop();

        // asynchronous reset during ACCESS
        set_ex(2'd0, 32'h55, 1'b1);
        ex_pc = 30'h9;
        @(negedge clk);
        chk("rs_pre_en", mem_en, 1'b1);
        set_ex(2'd1, 32'h44, 1'b1);
        bif.bus_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rs_as_pre", bif.bus_as, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rs_as", bif.bus_as, 1'b0);
        chk("rs_req", bif.bus_req, 1'b0);
        chk("rs_en", mem_en, 1'b0);
        chk("rs_out", mem_out, 32'd0);
        chk("rs_pc", mem_pc, 30'd0);
        nop();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rs_rel_req", bif.bus_req, 1'b0);
        chk("rs_rel_busy", busy, 1'b0);
        set_ex(2'd1, 32'h44, 1'b1);
        #1;
        chk("rs_restart_req", bif.bus_req, 1'b1);
        chk("rs_restart_as", bif.bus_as, 1'b0);
        nop();
        bif.bus_grant = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
